// File: rtl/cardinal_nic.sv
// cardinal_nic: processor-side NIC for one cardinal mesh router port.
// Output queue injects flits under ready/polarity gating; input queue captures router flits.
module cardinal_nic #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic        net_so,
    output logic [63:0] net_do,
    input  logic        net_ro,
    input  logic        net_si,
    input  logic [63:0] net_di,
    output logic        net_ri,
    input  logic        net_polarity
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [63:0]   in_mem  [DEPTH];
    logic [63:0]   out_mem [DEPTH];
    logic [AW-1:0] in_rd, in_wr, out_rd, out_wr;
    logic [CW-1:0] in_count, out_count;
    logic          overflow;

    logic          rd_en, wr_en;
    logic          in_empty, in_push, in_pop;
    logic          out_full, out_nonempty, out_push, inject;
    logic [63:0]   out_head, rd_data;

    assign rd_en        = nicEn & ~nicWrEn;
    assign wr_en        = nicEn & nicWrEn;
    assign in_empty     = (in_count == '0);
    assign out_full     = (out_count == FULL);
    assign out_nonempty = (out_count != '0);
    assign out_head     = out_mem[out_rd];

    assign net_ri   = reset & (in_count != FULL);
    assign in_push  = net_si & net_ri;
    assign in_pop   = rd_en & (addr == 2'd0) & ~in_empty;
    assign out_push = reset & wr_en & (addr == 2'd2) & ~out_full;

    // net_so in the eligibility term spaces flits so router backpressure can land
    assign inject = out_nonempty & net_ro & ~net_so
                  & (out_head[63] == net_polarity);

    always_comb begin
        rd_data = '0;
        unique case (addr)
            2'd0: rd_data = in_empty ? '0 : in_mem[in_rd];
            2'd1: rd_data = {48'h0, 8'(in_count), 7'h0, ~in_empty};
            2'd3: rd_data = {48'h0, 8'(out_count), 6'h0, overflow, out_full};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wr] <= net_di;
        if (out_push)
            out_mem[out_wr] <= d_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_rd    <= '0;
            in_wr    <= '0;
            in_count <= '0;
        end else begin
            if (in_push)
                in_wr <= bump(in_wr);
            if (in_pop)
                in_rd <= bump(in_rd);
            in_count <= in_count + CW'(in_push) - CW'(in_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_rd    <= '0;
            out_wr    <= '0;
            out_count <= '0;
        end else begin
            if (out_push)
                out_wr <= bump(out_wr);
            if (inject)
                out_rd <= bump(out_rd);
            out_count <= out_count + CW'(out_push) - CW'(inject);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            overflow <= 1'b0;
        else if (wr_en && addr == 2'd2 && out_full)
            overflow <= 1'b1;
        else if (wr_en && addr == 2'd3 && d_in[1])
            overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            net_so <= 1'b0;
            net_do <= '0;
            d_out  <= '0;
        end else begin
            net_so <= inject;
            if (inject)
                net_do <= out_head;
            if (rd_en)
                d_out <= rd_data;
        end
    end

endmodule
